// File: rtl/regfile_seq_adder.sv
// Register-file-fed adder/subtractor that walks the operands one DW-bit chunk per cycle,
// rippling the carry between cycles and reporting completion with a busy/done handshake.
module regfile_seq_adder #(
  parameter int DW     = 4,
  parameter int NCHUNK = 4,
  localparam int AW    = $clog2(2 * NCHUNK),
  localparam int OW    = DW * NCHUNK
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] read_value,
  input  logic          start,
  input  logic          sub,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] sum,
  output logic          cout,
  output logic          ovf
);
  localparam int NE = 2 * NCHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;
  logic [OW-1:0] sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic [OW-1:0] opa_q, opa_d;
  logic [OW-1:0] opb_q, opb_d;
  logic [DW-1:0] regs_q [NE];
  logic [DW-1:0] regs_d [NE];

  logic          addr_ok;
  logic          accept;
  logic [DW-1:0] a_chunk, b_chunk, s_chunk;
  logic          c_chunk, c_msb_in;

  assign addr_ok = (32'(addr) < NE);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign accept  = start && (state_q != RUN);

  always_comb begin
    read_value = '0;
    if (addr_ok) read_value = regs_q[addr];
  end

  always_comb begin
    regs_d = regs_q;
    if (we && !busy && addr_ok) regs_d[addr] = data;
  end

  // Operands are snapshotted at start so a same-cycle write cannot leak into the run.
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    if (accept) begin
      for (int i = 0; i < NCHUNK; i++) begin
        opa_d[i*DW +: DW] = regs_q[i];
        opb_d[i*DW +: DW] = regs_q[NCHUNK + i];
      end
    end
  end

  always_comb begin
    a_chunk            = opa_q[int'(idx_q)*DW +: DW];
    b_chunk            = opb_q[int'(idx_q)*DW +: DW] ^ {DW{sub_q}};
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{DW{1'b0}}, carry_q};
    c_msb_in           = s_chunk[DW-1] ^ a_chunk[DW-1] ^ b_chunk[DW-1];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*DW +: DW] = s_chunk;
        carry_d = c_chunk;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = c_chunk;
          ovf_d   = c_msb_in ^ c_chunk;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      for (int i = 0; i < NE; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      regs_q  <= regs_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/regfile_seq_adder.md
Name: regfile_seq_adder

Overview:
- Parametrised register-file-fed adder/subtractor.
- Operands A and B are written chunk-by-chunk into an internal register file.
- On a start pulse, the block computes A+B or A-B one DW-bit chunk per cycle, carrying between cycles.
- It reports the result with a busy/done handshake. It is the multi-cycle, width-generalised successor of the 4-bit-chunk, 8-register, 16-bit combinational register-file adder.

Parameters:
- DW, 4, chunk width in bits; equals the register-file entry width.
- NCHUNK, 4, chunks per operand; operand width OW = DW*NCHUNK.
- AW (localparam), clog2(2*NCHUNK), register-file address width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  register-file write enable.
- addr  in  AW  register-file address for both read and write.
- data  in  DW  write data.
- read_value  out  DW  combinational readout, regs[addr]; 0 if addr >= 2*NCHUNK.
- start  in  1  begin operation, single-cycle pulse.
- sub  in  1  operation select, sampled with start: 0 = A+B, 1 = A-B.
- busy  out  1  high while chunks are being computed.
- done  out  1  one-cycle pulse when the result is final.
- sum  out  OW  result register.
- cout  out  1  final carry; for subtraction, 1 = no borrow (A >= B unsigned).
- ovf  out  1  two's-complement signed overflow of the final result.

Behaviour:
- Register file and operand mapping
  - 2*NCHUNK entries of DW bits.
  - Entries 0..NCHUNK-1 hold A, with entry 0 as the LS chunk.
  - Entries NCHUNK..2*NCHUNK-1 hold B, with entry NCHUNK as the LS chunk.
- Write rules
  - Write occurs on a rising edge when we=1, busy=0 and addr < 2*NCHUNK.
  - Writes while busy=1 are dropped so operands stay stable.
  - Out-of-range writes are dropped.
- Reset (asynchronous)
  - All entries, sum, cout, ovf, busy, done, the carry register and the chunk index are cleared to 0.
  - FSM goes to IDLE.
  - A reset mid-operation aborts the operation; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 is accepted. Latch sub, set carry=sub, set idx=0, go to RUN. If we and start are both high in the same cycle, the write is performed and the operation uses the pre-write register contents.
  - RUN (busy=1): each cycle, sum chunk idx <= A[idx] + (B[idx] XOR {DW{sub}}) + carry (low DW bits), carry <= carry-out of that chunk, idx <= idx+1. After idx = NCHUNK-1 is processed, go to DONE. start is ignored in RUN.
  - DONE (done=1, busy=0): held for exactly one cycle. start in DONE is accepted as in IDLE and the next state is RUN; otherwise the next state is IDLE.
- cout and ovf
  - Registered on the edge that processes the last chunk, so they are valid when done=1.
  - cout = carry-out of the MS chunk.
  - ovf = carry-into MSB XOR carry-out of MSB.
- Latency
  - start is sampled at edge T.
  - busy is high for cycles T+1 .. T+NCHUNK.
  - done is high in cycle T+NCHUNK+1, and sum/cout/ovf are final from then on.
- Output holding and visibility
  - sum, cout and ovf hold until the next accepted start.
  - During RUN, sum chunks update progressively. Upper chunks keep stale values until overwritten, so sum is valid only once done=1.
  - cout and ovf keep their previous values during RUN.
- Widths
  - All arithmetic is modulo 2^OW.
  - NCHUNK=1 is legal: busy lasts 1 cycle.

Test Plan:
- Defaults (DW=4, NCHUNK=4). Write A=0x1234 (entries 0..3 = 4,3,2,1) and B=0x0FFF; pulse start with sub=0 -> busy 4 cycles, done at T+5, sum=0x2233, cout=0, ovf=0.
- A=0xFFFF, B=0x0001, add -> sum=0x0000, cout=1, ovf=0. Then A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, ovf=1.
- A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0. Then A=0x0007, B=0x0005 -> sum=0x0002, cout=1, ovf=0.
- During RUN: write entry 0 with 0xF and pulse start again -> entry 0 unchanged (check via read_value), exactly one done pulse, sum unaffected by either. start in the DONE cycle -> new run begins with busy high the next cycle.
- Assert reset at T+2 of an operation -> all outputs and entries read 0 immediately, no done pulse. A subsequent start with zeroed operands -> sum=0, cout=0.
- Parameter sweep: DW=8 with NCHUNK=2, and DW=4 with NCHUNK=1 -> random add/sub vectors match a reference model; done at T+NCHUNK+1; read_value for out-of-range addr = 0.
